// File: rtl/xtea_block_engine.sv
// Iterative XTEA encrypt/decrypt engine: one 64-bit block per valid/ready
// handshake, UNROLL cycles per clock, result held until the consumer takes it.
module xtea_block_engine #(
  parameter int unsigned CYCLES = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic         mode,
  input  logic [63:0]  din,
  input  logic [127:0] key,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [63:0]  dout,
  output logic         busy
);

  localparam logic [31:0] DELTA = 32'h9E3779B9;
  localparam int unsigned N     = CYCLES / UNROLL;
  localparam logic [63:0] SUM_FULL = 64'(CYCLES) * 64'h0000_0000_9E37_79B9;
  localparam logic [31:0] SUM_DEC  = SUM_FULL[31:0];

  if (!((UNROLL == 1 || UNROLL == 2 || UNROLL == 4) &&
        CYCLES >= 1 && CYCLES <= 64 && (CYCLES % UNROLL) == 0)) begin : g_bad_params
    $error("xtea_block_engine: illegal CYCLES/UNROLL combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  logic [6:0]   cnt;
  logic [31:0]  sum;
  logic [31:0]  v0;
  logic [31:0]  v1;
  logic [127:0] k;
  logic         dec;

  logic [31:0]  nv0;
  logic [31:0]  nv1;
  logic [31:0]  nsum;

  function automatic logic [31:0] mix(input logic [31:0] v);
    return ((v << 4) ^ (v >> 5)) + v;
  endfunction

  function automatic logic [31:0] kw(input logic [127:0] kk, input logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = kk[127:96];
      2'd1:    w = kk[95:64];
      2'd2:    w = kk[63:32];
      default: w = kk[31:0];
    endcase
    return w;
  endfunction

  // UNROLL XTEA cycles chained in one clock; sum travels with the data.
  always_comb begin
    nv0  = v0;
    nv1  = v1;
    nsum = sum;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (!dec) begin
        nv0  = nv0 + (mix(nv1) ^ (nsum + kw(k, nsum[1:0])));
        nsum = nsum + DELTA;
        nv1  = nv1 + (mix(nv0) ^ (nsum + kw(k, nsum[12:11])));
      end else begin
        nv1  = nv1 - (mix(nv0) ^ (nsum + kw(k, nsum[12:11])));
        nsum = nsum - DELTA;
        nv0  = nv0 - (mix(nv1) ^ (nsum + kw(k, nsum[1:0])));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state   <= IDLE;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
      busy    <= 1'b0;
      dout    <= '0;
      cnt     <= '0;
      sum     <= '0;
      v0      <= '0;
      v1      <= '0;
      k       <= '0;
      dec     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            v0     <= din[63:32];
            v1     <= din[31:0];
            k      <= key;
            dec    <= mode;
            cnt    <= 7'(N);
            sum    <= mode ? SUM_DEC : '0;
            state  <= RUN;
            in_rdy <= 1'b0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          v0  <= nv0;
          v1  <= nv1;
          sum <= nsum;
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            dout    <= {nv0, nv1};
            out_vld <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_rdy) begin
            out_vld <= 1'b0;
            busy    <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
